// File: rtl/regfile_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_pkg
// Shared constants for the register file and everything that writes into it:
//   REG_WIDTH   data width of one architectural register
//   REG_NUM     number of registers behind the shared write port
//   REG_ADDR_W  width of a register index
//   REG_NUM_REQ default number of writeback sources competing for the port
//   wb_req_t    one writeback request (target index + data), as produced by
//               the writeback stage
// ---------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

  localparam int REG_WIDTH   = 16;
  localparam int REG_NUM     = 8;
  localparam int REG_ADDR_W  = $clog2(REG_NUM);
  localparam int REG_NUM_REQ = 3;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_WIDTH-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
// Bundles the writeback request bus and the register-file write port.
//   req_valid  NUM_REQ          per-requester write request
//   req_addr   NUM_REQ*ADDR_W   packed register indices, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   NUM_REQ*WIDTH    packed write data, requester i at [i*WIDTH +: WIDTH]
//   req_ready  NUM_REQ          one-hot-or-zero grant back to the requesters
//   wr_enable  NUM_REG          one-hot-or-zero register enables
//   wr_d       WIDTH            data broadcast to every register d input
//   addr_err   1                pulse: an accepted request addressed no register
// Modports:
//   master  the requester side (drives the request bus, sees the write port)
//   slave   the arbiter side
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int WIDTH   = REG_WIDTH,
  parameter int NUM_REG = REG_NUM,
  parameter int NUM_REQ = REG_NUM_REQ
) ();

  localparam int ADDR_W = $clog2(NUM_REG);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]  req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REG-1:0]        wr_enable;
  logic [WIDTH-1:0]          wr_d;
  logic                      addr_err;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_enable, wr_d, addr_err
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_enable, wr_d, addr_err
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_rr_arbiter
// Round-robin arbiter with a pointer to the most recently granted requester.
//   clk    in  1   rising-edge clock
//   reset  in  1   asynchronous, active-low; pointer returns to N-1 so that
//                  requester 0 is first in line, and no grant while low
//   en     in  1   0 = grant nothing this cycle
//   req    in  N   request vector
//   grant  out N   one-hot-or-zero grant, combinational
// The grant goes to the first set request scanning upward from pointer+1,
// wrapping at N. A grant always coincides with a transfer (grant is only given
// to a valid requester), so the pointer simply follows the granted index.
// ---------------------------------------------------------------------------
module regfile_write_arbiter_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] idx;
  logic             found;
  int               sum;

  always_comb begin
    grant    = '0;
    ptr_next = ptr_reg;
    idx      = '0;
    found    = 1'b0;
    sum      = 0;
    // Reset is folded in here so req_ready is low for as long as reset is held.
    if (en && reset) begin
      for (int k = 1; k <= N; k++) begin
        sum = int'(ptr_reg) + k;
        if (sum >= N) begin
          sum = sum - N;
        end
        idx = PTR_W'(sum);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          ptr_next   = idx;
          found      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= PTR_W'(N - 1);
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Shares one register-file write port between NUM_REQ writeback sources.
// A round-robin arbiter accepts one request per cycle (valid/ready); the
// accepted index is decoded to a one-hot enable and registered together with
// the data, so a transfer in cycle N writes the register at the end of N+1.
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-low; clears enables/data/error
//   stall  in   1      1 = accept nothing this cycle
//   bus    slave       request bus in, write port out (see regfile_write_arbiter_if)
// Build option:
//   REGFILE_ZERO_REG_EN  register 0 is hardwired zero: writes to index 0 are
//                        still accepted but wr_enable[0] never rises.
// ---------------------------------------------------------------------------
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int WIDTH   = REG_WIDTH,
  parameter int NUM_REG = REG_NUM,
  parameter int NUM_REQ = REG_NUM_REQ
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  regfile_write_arbiter_if.slave  bus
);

  localparam int ADDR_W = $clog2(NUM_REG);

  logic [NUM_REQ-1:0] grant;
  logic               transfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [WIDTH-1:0]   sel_data;
  logic [NUM_REG-1:0] wr_enable_next;
  logic               addr_err_next;
  logic [NUM_REG-1:0] wr_enable_reg;
  logic [WIDTH-1:0]   wr_d_reg;
  logic               addr_err_reg;

  regfile_write_arbiter_rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (~stall),
    .req   (bus.req_valid),
    .grant (grant)
  );

  assign bus.req_ready = grant;
  // Grants only go to valid requesters, so any grant bit is a transfer.
  assign transfer      = |grant;

  // One-hot grant selects the accepted request.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Address decode; an index past the last register matches no enable bit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REG; gi++) begin : g_dec
      if (gi == 0) begin : g_reg0
`ifdef REGFILE_ZERO_REG_EN
        assign wr_enable_next[gi] = 1'b0;
`else
        assign wr_enable_next[gi] = transfer && (sel_addr == ADDR_W'(gi));
`endif
      end else begin : g_regn
        assign wr_enable_next[gi] = transfer && (sel_addr == ADDR_W'(gi));
      end
    end
  endgenerate

  assign addr_err_next = transfer && (int'(sel_addr) >= NUM_REG);

  // Output stage; wr_d keeps its last value when nothing is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_enable_reg <= '0;
      wr_d_reg      <= '0;
      addr_err_reg  <= 1'b0;
    end else begin
      wr_enable_reg <= wr_enable_next;
      addr_err_reg  <= addr_err_next;
      if (transfer) begin
        wr_d_reg <= sel_data;
      end
    end
  end

  assign bus.wr_enable = wr_enable_reg;
  assign bus.wr_d      = wr_d_reg;
  assign bus.addr_err  = addr_err_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Self-checking bench: table of hand-derived vectors for reset, single write,
// fairness, stall and zero register; hand sequences for reset during a
// transfer; then randomized traffic against a behavioural model. A second
// instance with 6 registers shares the request inputs so that out-of-range
// indices (addr_err) are exercised.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  logic stall;

  regfile_write_arbiter_if #(.WIDTH(16), .NUM_REG(8), .NUM_REQ(3)) bus ();
  regfile_write_arbiter_if #(.WIDTH(16), .NUM_REG(6), .NUM_REQ(3)) bus6 ();

  assign bus6.req_valid = bus.req_valid;
  assign bus6.req_addr  = bus.req_addr;
  assign bus6.req_data  = bus.req_data;

  regfile_write_arbiter #(.WIDTH(16), .NUM_REG(8), .NUM_REQ(3)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .bus   (bus.slave)
  );

  regfile_write_arbiter #(.WIDTH(16), .NUM_REG(6), .NUM_REQ(3)) dut6 (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .bus   (bus6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] v, input logic [8:0] a,
                       input logic [47:0] d);
    stall         = st;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
  endtask

  typedef struct {
    logic        stall;
    logic [2:0]  valid;
    logic [8:0]  addr;    // {a2, a1, a0}
    logic [47:0] data;    // {d2, d1, d0}
    logic [2:0]  ready;   // expected grant this cycle
    logic [7:0]  wen;     // expected enables (from previous cycle's transfer)
    logic [15:0] wd;      // expected write data
  } vec_t;

  localparam logic [8:0]  FA = {3'd4, 3'd2, 3'd1};
  localparam logic [47:0] FD = {16'h0012, 16'h0011, 16'h0010};

  vec_t tbl[14];

  // Random-phase model state
  int          last;
  bit          pend[3];
  wb_req_t     preq[3];
  logic [7:0]  ew;
  logic [5:0]  ew6;
  logic [15:0] ed;
  logic        ee6;
  logic [2:0]  er;
  int          g;
  int          a;
  logic        st;

  initial begin
    tbl[0]  = '{1'b0, 3'b111, FA, FD, 3'b001, 8'h00, 16'h0000};
    tbl[1]  = '{1'b0, 3'b111, FA, FD, 3'b010, 8'h02, 16'h0010};
    tbl[2]  = '{1'b0, 3'b111, FA, FD, 3'b100, 8'h04, 16'h0011};
    tbl[3]  = '{1'b0, 3'b111, FA, FD, 3'b001, 8'h10, 16'h0012};
    tbl[4]  = '{1'b0, 3'b111, FA, FD, 3'b010, 8'h02, 16'h0010};
    tbl[5]  = '{1'b0, 3'b111, FA, FD, 3'b100, 8'h04, 16'h0011};
    tbl[6]  = '{1'b1, 3'b111, FA, FD, 3'b000, 8'h10, 16'h0012};
    tbl[7]  = '{1'b1, 3'b111, FA, FD, 3'b000, 8'h00, 16'h0012};
    tbl[8]  = '{1'b0, 3'b111, FA, FD, 3'b001, 8'h00, 16'h0012};
    tbl[9]  = '{1'b0, 3'b010, {3'd0, 3'd3, 3'd0}, {16'h0, 16'h0002, 16'h0}, 3'b010, 8'h02, 16'h0010};
    tbl[10] = '{1'b0, 3'b000, 9'd0, 48'd0, 3'b000, 8'h08, 16'h0002};
    tbl[11] = '{1'b0, 3'b100, 9'd0, {16'h0004, 32'h0}, 3'b100, 8'h00, 16'h0002};
    tbl[12] = '{1'b0, 3'b000, 9'd0, 48'd0, 3'b000, (ZERO_EN ? 8'h00 : 8'h01), 16'h0004};
    tbl[13] = '{1'b0, 3'b000, 9'd0, 48'd0, 3'b000, 8'h00, 16'h0004};

    // Reset held with every requester valid
    reset = 1'b0;
    drive(1'b0, 3'b111, FA, FD);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("reset_ready", 32'(bus.req_ready), 32'd0);
      chk("reset_wen", 32'(bus.wr_enable), 32'd0);
      chk("reset_wd", 32'(bus.wr_d), 32'd0);
      chk("reset_err", 32'(bus.addr_err), 32'd0);
    end
    @(posedge clk);
    #2 reset = 1'b1;

    // Table: fairness, stall, single write, zero register
    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      drive(tbl[r].stall, tbl[r].valid, tbl[r].addr, tbl[r].data);
      #1;
      $display("row %0d stall=%0b valid=%b ready=%b wen=%b wd=%h", r, tbl[r].stall,
               tbl[r].valid, bus.req_ready, bus.wr_enable, bus.wr_d);
      chk($sformatf("tbl%0d_ready", r), 32'(bus.req_ready), 32'(tbl[r].ready));
      chk($sformatf("tbl%0d_wen", r), 32'(bus.wr_enable), 32'(tbl[r].wen));
      chk($sformatf("tbl%0d_wd", r), 32'(bus.wr_d), 32'(tbl[r].wd));
      chk($sformatf("tbl%0d_err", r), 32'(bus.addr_err), 32'd0);
    end

    // Reset falls while a request is being granted: nothing may be written
    @(negedge clk);
    drive(1'b0, 3'b001, {6'd0, 3'd5}, {32'd0, 16'h0003});
    #1;
    chk("rst_a_ready", 32'(bus.req_ready), 32'b001);
    #2 reset = 1'b0;
    #1;
    chk("rst_a_ready_low", 32'(bus.req_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("rst_a_wen", 32'(bus.wr_enable), 32'd0);
    end
    drive(1'b0, 3'b000, 9'd0, 48'd0);
    @(posedge clk);
    #2 reset = 1'b1;

    // Reset falls while the write is pending: enable cleared asynchronously
    @(negedge clk);
    drive(1'b0, 3'b001, {6'd0, 3'd5}, {32'd0, 16'h0003});
    #1;
    chk("rst_b_ready", 32'(bus.req_ready), 32'b001);
    @(posedge clk);
    #1;
    chk("rst_b_wen_pending", 32'(bus.wr_enable), 32'h20);
    chk("rst_b_wd_pending", 32'(bus.wr_d), 32'h0003);
    drive(1'b0, 3'b000, 9'd0, 48'd0);
    #1 reset = 1'b0;
    #1;
    chk("rst_b_wen_drop", 32'(bus.wr_enable), 32'd0);
    chk("rst_b_wd_clear", 32'(bus.wr_d), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;

    // Randomized traffic against the behavioural model
    last = 2;
    ew   = '0;
    ew6  = '0;
    ed   = '0;
    ee6  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0;
      preq[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]      = 1'b1;
          preq[i].addr = 3'($urandom_range(0, 7));
          preq[i].data = 16'($urandom);
        end
      end
      st    = ($urandom_range(0, 3) == 0);
      stall = st;
      for (int i = 0; i < 3; i++) begin
        bus.req_valid[i]          = pend[i];
        bus.req_addr[i*3 +: 3]    = preq[i].addr;
        bus.req_data[i*16 +: 16]  = preq[i].data;
      end
      // First pending requester after the last one served, in circular order
      g = -1;
      if (!st) begin
        for (int k = 1; k <= 3; k++) begin
          if (g < 0 && pend[(last + k) % 3]) g = (last + k) % 3;
        end
      end
      er = (g >= 0) ? 3'(1 << g) : 3'b000;
      #1;
      chk("rnd_ready", 32'(bus.req_ready), 32'(er));
      chk("rnd_ready6", 32'(bus6.req_ready), 32'(er));
      chk("rnd_wen", 32'(bus.wr_enable), 32'(ew));
      chk("rnd_wd", 32'(bus.wr_d), 32'(ed));
      chk("rnd_err", 32'(bus.addr_err), 32'd0);
      chk("rnd_wen6", 32'(bus6.wr_enable), 32'(ew6));
      chk("rnd_wd6", 32'(bus6.wr_d), 32'(ed));
      chk("rnd_err6", 32'(bus6.addr_err), 32'(ee6));
      if (g >= 0) begin
        a       = int'(preq[g].addr);
        last    = g;
        pend[g] = 1'b0;
        ed      = preq[g].data;
        ew      = (a < 8 && !(ZERO_EN && a == 0)) ? 8'(1 << a) : 8'h00;
        ew6     = (a < 6 && !(ZERO_EN && a == 0)) ? 6'(1 << a) : 6'h00;
        ee6     = (a >= 6);
        $display("cycle %0d grant req%0d addr=%0d data=%h", c, g, a, preq[g].data);
      end else begin
        ew  = '0;
        ew6 = '0;
        ee6 = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
